// File: rtl/screen_fetcher_pkg.sv
// Shared types and constants for the screen fetch path: line timing,
// fetch FSM states and ULA+ palette index helpers.
package screen_fetcher_pkg;

    localparam logic [8:0]  H_TOTAL          = 9'd448;
    localparam logic [8:0]  HC_FETCH_BEGIN   = 9'd440;
    localparam logic [8:0]  V_ACTIVE         = 9'd192;
    localparam logic [12:0] SCREEN_ATTR_BASE = 13'h1800;
    localparam logic [1:0]  SCREEN_PAGE_TAG  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        BMP,
        ATTR,
        PAL_INK,
        PAL_PAPER
    } fetch_state_t;

    // ULA+ ink entry: CLUT select from attr[7:6], ink colour from attr[2:0]
    function automatic logic [5:0] pal_ink_idx(input logic [7:0] attr);
        return {attr[7:6], 1'b0, attr[2:0]};
    endfunction

    // ULA+ paper entry: CLUT select from attr[7:6], paper colour from attr[5:3]
    function automatic logic [5:0] pal_paper_idx(input logic [7:0] attr);
        return {attr[7:6], 1'b1, attr[5:3]};
    endfunction

endpackage

// File: rtl/screen_fetcher_if.sv
// Bundle between the screen fetcher, memcontrol (VRAM request/data) and the
// pixel shifter (cell record). master = fetcher side.
interface screen_fetcher_if;

    logic [7:0]  vd;
    logic        screen_fetch;
    logic        screen_fetch_up;
    logic [14:0] screen_addr;
    logic [5:0]  screen_up_addr;
    logic        cell_valid;
    logic [7:0]  cell_bitmap;
    logic [7:0]  cell_attr;
    logic [7:0]  cell_ink;
    logic [7:0]  cell_paper;

    modport master (
        input  vd,
        output screen_fetch, screen_fetch_up, screen_addr, screen_up_addr,
        output cell_valid, cell_bitmap, cell_attr, cell_ink, cell_paper
    );

    modport slave (
        output vd,
        input  screen_fetch, screen_fetch_up, screen_addr, screen_up_addr,
        input  cell_valid, cell_bitmap, cell_attr, cell_ink, cell_paper
    );

endinterface

// File: rtl/screen_fetcher_addr_gen.sv
// Screen-memory offset generator: maps (line, column) to the bitmap byte
// with the Spectrum's interleaved line order, or to the attribute byte.
module screen_addr_gen
    import screen_fetcher_pkg::*;
(
    input  logic [7:0]  y,
    input  logic [4:0]  col,
    input  logic        is_attr,
    output logic [12:0] offset
);

    // Bitmap lines are interleaved third / pixel-row / char-row; attributes
    // are one byte per 8x8 character above the attribute base.
    always_comb begin
        if (is_attr)
            offset = SCREEN_ATTR_BASE | {3'b000, y[7:3], col};
        else
            offset = {y[7:6], y[2:0], y[5:3], col};
    end

endmodule

// File: rtl/screen_fetcher.sv
// VRAM read initiator for the video path. Per 8-pixel cell it fetches the
// bitmap and attribute bytes (plus ink/paper palette entries in ULA+ mode)
// and presents one cell record to the pixel shifter.
module screen_fetcher
    import screen_fetcher_pkg::*;
(
    input  logic              clk28,
    input  logic              rst_n,
    input  logic [8:0]        hc,
    input  logic [1:0]        hc_phase,
    input  logic [8:0]        vc,
    input  logic              up_en,
    screen_fetcher_if.master  bus
);

    logic [9:0]   hc_diff;
    logic [8:0]   rel;
    logic         win_active;
    logic [4:0]   slot;
    logic [4:0]   col;
    logic [12:0]  bmp_off;
    logic [12:0]  attr_off;

    fetch_state_t state_reg;
    logic [1:0]   sub_reg;
    logic         up_en_lat_reg;
    logic         done_reg;
    logic [7:0]   y_reg;
    logic [4:0]   col_reg;
    logic [7:0]   bmp_hold_reg;
    logic [7:0]   attr_hold_reg;
    logic [7:0]   ink_hold_reg;
    logic [7:0]   paper_hold_reg;
    logic         fetch_reg;
    logic         fetch_up_reg;
    logic [14:0]  addr_reg;
    logic [5:0]   up_addr_reg;
    logic         cell_valid_reg;
    logic [7:0]   cell_bitmap_reg;
    logic [7:0]   cell_attr_reg;
    logic [7:0]   cell_ink_reg;
    logic [7:0]   cell_paper_reg;

    // Position relative to the fetch window; a borrow means hc already wrapped.
    always_comb begin
        hc_diff    = {1'b0, hc} - {1'b0, HC_FETCH_BEGIN};
        rel        = hc_diff[9] ? (hc_diff[8:0] + H_TOTAL) : hc_diff[8:0];
        win_active = !rel[8] && (vc < V_ACTIVE);
        slot       = {rel[2:0], hc_phase};
        col        = rel[7:3];
    end

    // Bitmap address uses the live position (issued at slot 0); the attribute
    // address uses the position latched for the current cell.
    screen_addr_gen u_bmp_addr (
        .y       (vc[7:0]),
        .col     (col),
        .is_attr (1'b0),
        .offset  (bmp_off)
    );

    screen_addr_gen u_attr_addr (
        .y       (y_reg),
        .col     (col_reg),
        .is_attr (1'b1),
        .offset  (attr_off)
    );

    // Fetch sequencer: four clk28 per state, vd captured on the last sub-cycle.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sub_reg        <= 2'd0;
            up_en_lat_reg  <= 1'b0;
            done_reg       <= 1'b0;
            y_reg          <= 8'd0;
            col_reg        <= 5'd0;
            bmp_hold_reg   <= 8'd0;
            attr_hold_reg  <= 8'd0;
            ink_hold_reg   <= 8'd0;
            paper_hold_reg <= 8'd0;
            fetch_reg      <= 1'b0;
            fetch_up_reg   <= 1'b0;
            addr_reg       <= 15'd0;
            up_addr_reg    <= 6'd0;
        end else if (win_active && slot == 5'd0) begin
            // A new cell always starts here, aborting any unfinished fetch.
            state_reg     <= BMP;
            sub_reg       <= 2'd0;
            up_en_lat_reg <= up_en;
            done_reg      <= 1'b0;
            y_reg         <= vc[7:0];
            col_reg       <= col;
            fetch_reg     <= 1'b1;
            fetch_up_reg  <= 1'b0;
            addr_reg      <= {SCREEN_PAGE_TAG, bmp_off};
        end else if (!win_active) begin
            state_reg    <= IDLE;
            sub_reg      <= 2'd0;
            done_reg     <= 1'b0;
            fetch_reg    <= 1'b0;
            fetch_up_reg <= 1'b0;
        end else if (state_reg != IDLE) begin
            if (sub_reg != 2'd3) begin
                sub_reg <= sub_reg + 2'd1;
            end else begin
                sub_reg <= 2'd0;
                case (state_reg)
                    BMP: begin
                        bmp_hold_reg <= vd_in();
                        state_reg    <= ATTR;
                        addr_reg     <= {SCREEN_PAGE_TAG, attr_off};
                    end
                    ATTR: begin
                        attr_hold_reg <= vd_in();
                        if (up_en_lat_reg) begin
                            state_reg    <= PAL_INK;
                            fetch_up_reg <= 1'b1;
                            up_addr_reg  <= pal_ink_idx(vd_in());
                        end else begin
                            state_reg <= IDLE;
                            fetch_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                    PAL_INK: begin
                        ink_hold_reg <= vd_in();
                        state_reg    <= PAL_PAPER;
                        up_addr_reg  <= pal_paper_idx(attr_hold_reg);
                    end
                    PAL_PAPER: begin
                        paper_hold_reg <= vd_in();
                        state_reg      <= IDLE;
                        fetch_reg      <= 1'b0;
                        fetch_up_reg   <= 1'b0;
                        done_reg       <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                        fetch_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] vd_in();
        return bus.vd;
    endfunction

    // Cell record: loaded one cycle early so the strobe is high during slot 31.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cell_valid_reg  <= 1'b0;
            cell_bitmap_reg <= 8'd0;
            cell_attr_reg   <= 8'd0;
            cell_ink_reg    <= 8'd0;
            cell_paper_reg  <= 8'd0;
        end else if (win_active && slot == 5'd30 && done_reg && state_reg == IDLE) begin
            cell_valid_reg  <= 1'b1;
            cell_bitmap_reg <= bmp_hold_reg;
            cell_attr_reg   <= attr_hold_reg;
            cell_ink_reg    <= up_en_lat_reg ? ink_hold_reg : 8'd0;
            cell_paper_reg  <= up_en_lat_reg ? paper_hold_reg : 8'd0;
        end else begin
            cell_valid_reg  <= 1'b0;
        end
    end

    assign bus.screen_fetch    = fetch_reg;
    assign bus.screen_fetch_up = fetch_up_reg;
    assign bus.screen_addr     = addr_reg;
    assign bus.screen_up_addr  = up_addr_reg;
    assign bus.cell_valid      = cell_valid_reg;
    assign bus.cell_bitmap     = cell_bitmap_reg;
    assign bus.cell_attr       = cell_attr_reg;
    assign bus.cell_ink        = cell_ink_reg;
    assign bus.cell_paper      = cell_paper_reg;

endmodule

// File: tb/tb_screen_fetcher.sv
// Directed bench for screen_fetcher: drives hc/hc_phase like the video
// counters, feeds vd by hand and checks fetch requests and cell records.
module tb_screen_fetcher;

    logic       clk28;
    logic       rst_n;
    logic [8:0] hc;
    logic [1:0] hc_phase;
    logic [8:0] vc;
    logic       up_en;

    screen_fetcher_if bus ();

    screen_fetcher dut (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .hc       (hc),
        .hc_phase (hc_phase),
        .vc       (vc),
        .up_en    (up_en),
        .bus      (bus)
    );

    int total;
    int bad;
    int cnt_valid;
    int cnt_fetch;
    int cnt_up;

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk28: the edge consumes the current hc/hc_phase, then they advance.
    task automatic tick();
        @(posedge clk28);
        #1;
        cnt_valid += int'(bus.cell_valid);
        cnt_fetch += int'(bus.screen_fetch);
        cnt_up    += int'(bus.screen_fetch_up);
        if (hc_phase == 2'd3) begin
            hc_phase = 2'd0;
            hc = (hc == 9'd447) ? 9'd0 : hc + 9'd1;
        end else begin
            hc_phase = hc_phase + 2'd1;
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cnt_valid = 0;
        cnt_fetch = 0;
        cnt_up    = 0;
    endtask

    initial begin
        total = 0; bad = 0;
        clear_counts();
        rst_n = 1'b0; hc = 9'd300; hc_phase = 2'd0; vc = 9'd0; up_en = 1'b0;
        bus.vd = 8'h00;

        // reset state
        tick_n(3);
        chk("rst_fetch", 32'(bus.screen_fetch), 32'd0);
        chk("rst_addr", 32'(bus.screen_addr), 32'h0);
        chk("rst_valid", 32'(bus.cell_valid), 32'd0);
        chk("rst_up_addr", 32'(bus.screen_up_addr), 32'h0);
        rst_n = 1'b1;
        tick_n(2);

        // 1: vc=0, col 0, classic mode
        vc = 9'd0; hc = 9'd440; hc_phase = 2'd0;
        tick();
        chk("t1_bmp_fetch", 32'(bus.screen_fetch), 32'd1);
        chk("t1_bmp_addr", 32'(bus.screen_addr), 32'h4000);
        tick_n(3); bus.vd = 8'hAA; tick();
        chk("t1_attr_addr", 32'(bus.screen_addr), 32'h5800);
        chk("t1_attr_up", 32'(bus.screen_fetch_up), 32'd0);
        tick_n(3); bus.vd = 8'h47; tick();
        chk("t1_idle_fetch", 32'(bus.screen_fetch), 32'd0);
        tick_n(22);
        chk("t1_valid", 32'(bus.cell_valid), 32'd1);
        chk("t1_bitmap", 32'(bus.cell_bitmap), 32'hAA);
        chk("t1_attr", 32'(bus.cell_attr), 32'h47);
        chk("t1_ink", 32'(bus.cell_ink), 32'h0);
        clear_counts();
        tick_n(1761);
        chk("t1_cells_rest", 32'(cnt_valid), 32'd31);
        chk("t1_fetch_cycles", 32'(cnt_fetch), 32'd248);
        chk("t1_up_cycles", 32'(cnt_up), 32'd0);

        // 2: vc=100, col 5 (rel 40 -> hc 32)
        vc = 9'd100; hc = 9'd32; hc_phase = 2'd0;
        tick();
        chk("t2_bmp_addr", 32'(bus.screen_addr), 32'h4C85);
        tick_n(4);
        chk("t2_attr_addr", 32'(bus.screen_addr), 32'h5985);

        // 3: ULA+ palette fetch, attr C5
        vc = 9'd0; up_en = 1'b1; hc = 9'd440; hc_phase = 2'd0;
        clear_counts();
        tick();
        tick_n(3); bus.vd = 8'h3C; tick();
        tick_n(3); bus.vd = 8'hC5; tick();
        chk("t3_ink_up", 32'(bus.screen_fetch_up), 32'd1);
        chk("t3_ink_idx", 32'(bus.screen_up_addr), 32'h35);
        chk("t3_ink_fetch", 32'(bus.screen_fetch), 32'd1);
        tick_n(3); bus.vd = 8'h12; tick();
        chk("t3_paper_idx", 32'(bus.screen_up_addr), 32'h38);
        tick_n(3); bus.vd = 8'hE0; tick();
        chk("t3_idle_up", 32'(bus.screen_fetch_up), 32'd0);
        tick_n(14);
        chk("t3_up_cycles", 32'(cnt_up), 32'd8);
        chk("t3_valid", 32'(bus.cell_valid), 32'd1);
        chk("t3_bitmap", 32'(bus.cell_bitmap), 32'h3C);
        chk("t3_attr", 32'(bus.cell_attr), 32'hC5);
        chk("t3_ink", 32'(bus.cell_ink), 32'h12);
        chk("t3_paper", 32'(bus.cell_paper), 32'hE0);

        // 6: up_en toggled at slot 10 only affects the next cell
        up_en = 1'b0; bus.vd = 8'hC5; hc = 9'd440; hc_phase = 2'd0;
        tick_n(10);
        up_en = 1'b1;
        tick();
        chk("t6_keep_classic", 32'(bus.screen_fetch_up), 32'd0);
        tick_n(20);
        chk("t6_valid_a", 32'(bus.cell_valid), 32'd1);
        chk("t6_ink_a", 32'(bus.cell_ink), 32'h0);
        tick_n(10);
        chk("t6_new_up", 32'(bus.screen_fetch_up), 32'd1);
        chk("t6_new_idx", 32'(bus.screen_up_addr), 32'h35);
        tick();
        up_en = 1'b0;
        tick_n(21);
        chk("t6_valid_b", 32'(bus.cell_valid), 32'd1);
        chk("t6_ink_b", 32'(bus.cell_ink), 32'hC5);
        chk("t6_paper_b", 32'(bus.cell_paper), 32'hC5);

        // abort: window drops mid-fetch, no cell strobe for that cell
        up_en = 1'b0; vc = 9'd0; hc = 9'd440; hc_phase = 2'd0;
        tick_n(3);
        vc = 9'd192;
        tick();
        chk("ab_fetch_drop", 32'(bus.screen_fetch), 32'd0);
        vc = 9'd0;
        tick_n(27);
        chk("ab_no_valid", 32'(bus.cell_valid), 32'd0);

        // 4: vc=192, whole line without fetch
        vc = 9'd192; hc = 9'd440; hc_phase = 2'd0;
        clear_counts();
        tick_n(1792);
        chk("t4_fetch_cycles", 32'(cnt_fetch), 32'd0);
        chk("t4_valid_count", 32'(cnt_valid), 32'd0);

        // 5: reset during PAL_INK, then clean restart
        vc = 9'd0; up_en = 1'b1; bus.vd = 8'hC5; hc = 9'd440; hc_phase = 2'd0;
        tick_n(9);
        chk("t5_in_pal", 32'(bus.screen_fetch_up), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_fetch", 32'(bus.screen_fetch), 32'd0);
        chk("t5_rst_up", 32'(bus.screen_fetch_up), 32'd0);
        chk("t5_rst_addr", 32'(bus.screen_addr), 32'h0);
        chk("t5_rst_up_addr", 32'(bus.screen_up_addr), 32'h0);
        chk("t5_rst_bitmap", 32'(bus.cell_bitmap), 32'h0);
        #1;
        rst_n = 1'b1;
        up_en = 1'b0; hc = 9'd440; hc_phase = 2'd0;
        tick();
        chk("t5_restart_fetch", 32'(bus.screen_fetch), 32'd1);
        chk("t5_restart_addr", 32'(bus.screen_addr), 32'h4000);
        chk("t5_restart_up", 32'(bus.screen_fetch_up), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
